// File: rtl/im_loader_if.sv
// Byte-stream and instruction-memory write bus between a program source and im_loader.
// The loader uses the slave modport; the source/memory side uses master.
interface im_loader_if #(
  parameter int IMW = 4,
  parameter int IW  = 32
);
  logic [7:0]     in_byte;
  logic           in_valid;
  logic           in_ready;
  logic           im_we;
  logic [IMW-1:0] im_addr;
  logic [IW-1:0]  im_wdata;

  modport master (
    output in_byte, in_valid,
    input  in_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  in_byte, in_valid,
    output in_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/im_loader.sv
// Loads a length-prefixed byte stream into instruction memory and pulses start when done.
// Optional trailing checksum byte is enabled by defining IM_LOADER_CSUM_EN.
module im_loader #(
  parameter int IMW = 4,
  parameter int IW  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_req,
  im_loader_if.slave  bus,
  output logic        start,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int BPW = IW / 8;
  localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [32:0] CAP = 33'd1 << IMW;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
`ifdef IM_LOADER_CSUM_EN
    CSUM,
`endif
    START,
    DONE
  } state_t;

  state_t         state_reg;
  logic           in_ready_reg;
  logic           im_we_reg;
  logic [IMW-1:0] im_addr_reg;
  logic [IW-1:0]  im_wdata_reg;
  logic           start_reg;
  logic           busy_reg;
  logic           done_reg;
  logic           err_reg;
  logic [BIW-1:0] byte_idx_reg;
  logic [IW-1:0]  word_reg;
  logic [IMW-1:0] len_reg;
`ifdef IM_LOADER_CSUM_EN
  logic [7:0]     csum_reg;
`endif

  logic [IW-1:0]  word_next;
  logic           accept;
  logic           len_ok;
  logic           last_byte;

  assign accept    = bus.in_valid & in_ready_reg;
  assign len_ok    = ({25'd0, bus.in_byte} < CAP);
  assign last_byte = (byte_idx_reg == BIW'(BPW - 1));

  // Little-endian packing: the incoming byte lands in the lane selected by byte_idx.
  generate
    for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
      assign word_next[gi*8 +: 8] = (byte_idx_reg == BIW'(gi)) ? bus.in_byte : word_reg[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      in_ready_reg <= 1'b0;
      im_we_reg    <= 1'b0;
      im_addr_reg  <= '0;
      im_wdata_reg <= '0;
      start_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      byte_idx_reg <= '0;
      word_reg     <= '0;
      len_reg      <= '0;
`ifdef IM_LOADER_CSUM_EN
      csum_reg     <= '0;
`endif
    end else begin
      im_we_reg <= 1'b0;
      start_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (load_req) begin
            err_reg      <= 1'b0;
            busy_reg     <= 1'b1;
            in_ready_reg <= 1'b1;
            state_reg    <= HDR;
          end
        end
        HDR: begin
          if (accept) begin
            if (!len_ok) begin
              err_reg      <= 1'b1;
              done_reg     <= 1'b1;
              busy_reg     <= 1'b0;
              in_ready_reg <= 1'b0;
              state_reg    <= DONE;
            end else begin
              len_reg      <= IMW'(bus.in_byte);
              byte_idx_reg <= '0;
              im_addr_reg  <= '0;
              word_reg     <= '0;
`ifdef IM_LOADER_CSUM_EN
              csum_reg     <= '0;
`endif
              state_reg    <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            word_reg <= word_next;
`ifdef IM_LOADER_CSUM_EN
            csum_reg <= csum_reg + bus.in_byte;
`endif
            if (last_byte) begin
              byte_idx_reg <= '0;
              im_wdata_reg <= word_next;
              im_we_reg    <= 1'b1;
              in_ready_reg <= 1'b0;
              state_reg    <= WRITE;
            end else begin
              byte_idx_reg <= byte_idx_reg + BIW'(1);
            end
          end
        end
        WRITE: begin
          // The header bound guarantees im_addr reaches len_reg before it can wrap.
          if (im_addr_reg == len_reg) begin
`ifdef IM_LOADER_CSUM_EN
            in_ready_reg <= 1'b1;
            state_reg    <= CSUM;
`else
            start_reg    <= 1'b1;
            state_reg    <= START;
`endif
          end else begin
            im_addr_reg  <= im_addr_reg + IMW'(1);
            in_ready_reg <= 1'b1;
            state_reg    <= DATA;
          end
        end
`ifdef IM_LOADER_CSUM_EN
        CSUM: begin
          if (accept) begin
            in_ready_reg <= 1'b0;
            if (bus.in_byte == csum_reg) begin
              start_reg <= 1'b1;
              state_reg <= START;
            end else begin
              err_reg   <= 1'b1;
              done_reg  <= 1'b1;
              busy_reg  <= 1'b0;
              state_reg <= DONE;
            end
          end
        end
`endif
        START: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= DONE;
        end
        DONE: begin
          if (load_req) begin
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            busy_reg     <= 1'b1;
            in_ready_reg <= 1'b1;
            state_reg    <= HDR;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_reg;
  assign bus.im_we    = im_we_reg;
  assign bus.im_addr  = im_addr_reg;
  assign bus.im_wdata = im_wdata_reg;
  assign start        = start_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign err          = err_reg;
endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: expected writes are queued as bytes are streamed and
// popped by a monitor on every im_we pulse.
module tb_im_loader;
  localparam int IMW = 4;
  localparam int IW  = 32;
  localparam int BPW = IW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_req = 1'b0;
  logic start, busy, done, err;

  im_loader_if #(.IMW(IMW), .IW(IW)) bus ();

  im_loader #(.IMW(IMW), .IW(IW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_req (load_req),
    .bus      (bus),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IMW-1:0] a;
    logic [IW-1:0]  d;
  } wr_t;

  wr_t            exp_q[$];
  logic [7:0]     tx_q[$];
  wr_t            mon_e;
  int             tests = 0;
  int             fails = 0;
  int             start_cnt = 0;
  int             we_cnt = 0;
  logic [IMW-1:0] last_addr = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (start) start_cnt++;
      if (bus.im_we) begin
        we_cnt++;
        last_addr = bus.im_addr;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: got addr %0d data %h, required no write", bus.im_addr, bus.im_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          if (bus.im_addr !== mon_e.a || bus.im_wdata !== mon_e.d) begin
            fails++;
            $display("FAIL write: got addr %0d data %h, required addr %0d data %h",
                     bus.im_addr, bus.im_wdata, mon_e.a, mon_e.d);
          end else begin
            $display("[TB] write addr %0d data %h", bus.im_addr, bus.im_wdata);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int gap, output int waited);
    waited = 0;
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      tests++;
      fails++;
      $display("FAIL in_ready_timeout: got in_ready %b after %0d cycles, required 1", bus.in_ready, waited);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
  endtask

  // csum_mode: 0 = correct checksum, 1 = corrupted checksum, 2 = no checksum byte sent
  task automatic do_load(input logic [7:0] len, input int gap, input int csum_mode, output int max_wait);
    int             w;
    int             addr;
    logic [IW-1:0]  word;
    logic [7:0]     sum;
    logic [IMW-1:0] a;
    max_wait = 0;
    addr = 0;
    word = '0;
    sum  = '0;
    pulse_load();
    send_byte(len, gap, w);
    for (int i = 0; i < tx_q.size(); i++) begin
      word[(i % BPW)*8 +: 8] = tx_q[i];
      sum = sum + tx_q[i];
      if (i % BPW == BPW - 1) begin
        a = IMW'(addr);
        exp_q.push_back({a, word});
        addr++;
      end
      send_byte(tx_q[i], gap, w);
      if (w > max_wait) max_wait = w;
    end
`ifdef IM_LOADER_CSUM_EN
    if (csum_mode != 2 && tx_q.size() > 0) begin
      send_byte((csum_mode == 1) ? 8'(sum + 8'd1) : sum, gap, w);
    end
`else
    if (csum_mode > 2) $display("[TB] unused checksum mode %0d", csum_mode);
`endif
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL done_timeout: got done %b, required 1", done);
    end
  endtask

  task automatic load_basic_stream();
    tx_q = {8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
  endtask

  task automatic test_reset();
    bus.in_byte  = 8'h00;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #12;
    tests++;
    if ({bus.in_ready, bus.im_we, bus.im_addr, bus.im_wdata, start, busy, done, err} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%b we=%b addr=%h data=%h start=%b busy=%b done=%b err=%b, required all 0",
               bus.in_ready, bus.im_we, bus.im_addr, bus.im_wdata, start, busy, done, err);
    end
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    $display("[TB] reset checked");
  endtask

  task automatic test_basic();
    int s0 = start_cnt;
    int w0 = we_cnt;
    int mw;
    load_basic_stream();
    do_load(8'h01, 0, 0, mw);
`ifndef IM_LOADER_CSUM_EN
    @(negedge clk);
    tests++;
    if (bus.im_we !== 1'b1 || start !== 1'b0) begin
      fails++;
      $display("FAIL latency_we: got we=%b start=%b, required we=1 start=0", bus.im_we, start);
    end
    @(negedge clk);
    tests++;
    if (bus.im_we !== 1'b0 || start !== 1'b1) begin
      fails++;
      $display("FAIL latency_start: got we=%b start=%b, required we=0 start=1", bus.im_we, start);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || start !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL latency_done: got done=%b start=%b busy=%b, required 1 0 0", done, start, busy);
    end
`endif
    wait_done();
    tests++;
    if (start_cnt - s0 != 1 || we_cnt - w0 != 2 || err !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL basic_load: got starts=%0d writes=%0d err=%b pending=%0d, required 1 2 0 0",
               start_cnt - s0, we_cnt - w0, err, exp_q.size());
    end
    $display("[TB] basic load finished");
  endtask

  task automatic test_bubbles();
    int s0 = start_cnt;
    int w0 = we_cnt;
    int mw;
    load_basic_stream();
    do_load(8'h01, 3, 0, mw);
    wait_done();
    tests++;
    if (mw != 0) begin
      fails++;
      $display("FAIL bubble_ready: got max ready wait %0d cycles, required 0", mw);
    end
    tests++;
    if (start_cnt - s0 != 1 || we_cnt - w0 != 2 || err !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL bubble_load: got starts=%0d writes=%0d err=%b pending=%0d, required 1 2 0 0",
               start_cnt - s0, we_cnt - w0, err, exp_q.size());
    end
    $display("[TB] bubble load finished");
  endtask

  task automatic test_overflow();
    int s0 = start_cnt;
    int w0 = we_cnt;
    int mw;
    tx_q.delete();
    do_load(8'h10, 0, 2, mw);
    wait_done();
    repeat (3) @(negedge clk);
    tests++;
    if (err !== 1'b1 || busy !== 1'b0 || start_cnt - s0 != 0 || we_cnt - w0 != 0) begin
      fails++;
      $display("FAIL overflow: got err=%b busy=%b starts=%0d writes=%0d, required 1 0 0 0",
               err, busy, start_cnt - s0, we_cnt - w0);
    end
    $display("[TB] overflow header finished");
  endtask

  task automatic test_full();
    int s0 = start_cnt;
    int w0 = we_cnt;
    int mw;
    tx_q.delete();
    for (int i = 0; i < (1 << IMW) * BPW; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    do_load(8'h0F, 0, 0, mw);
    wait_done();
    tests++;
    if (we_cnt - w0 != 16 || last_addr !== 4'd15 || start_cnt - s0 != 1 || err !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL full_load: got writes=%0d last=%0d starts=%0d err=%b pending=%0d, required 16 15 1 0 0",
               we_cnt - w0, last_addr, start_cnt - s0, err, exp_q.size());
    end
    s0 = start_cnt;
    w0 = we_cnt;
    tx_q.delete();
    for (int i = 0; i < 2 * BPW; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    do_load(8'h01, 1, 0, mw);
    wait_done();
    tests++;
    if (we_cnt - w0 != 2 || last_addr !== 4'd1 || start_cnt - s0 != 1 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL reload: got writes=%0d last=%0d starts=%0d pending=%0d, required 2 1 1 0",
               we_cnt - w0, last_addr, start_cnt - s0, exp_q.size());
    end
    $display("[TB] full and reload finished");
  endtask

  task automatic test_abort();
    int s0 = start_cnt;
    int w0 = we_cnt;
    int mw;
    tx_q.delete();
    for (int i = 0; i < 2 * BPW; i++) tx_q.push_back(8'(8'h30 + i));
    do_load(8'h03, 0, 2, mw);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.in_ready, bus.im_we, bus.im_addr, bus.im_wdata, start, busy, done, err} !== '0) begin
      fails++;
      $display("FAIL abort_outputs: got rdy=%b we=%b addr=%h data=%h start=%b busy=%b done=%b err=%b, required all 0",
               bus.in_ready, bus.im_we, bus.im_addr, bus.im_wdata, start, busy, done, err);
    end
    tests++;
    if (we_cnt - w0 != 2 || start_cnt - s0 != 0) begin
      fails++;
      $display("FAIL abort_partial: got writes=%0d starts=%0d, required 2 0", we_cnt - w0, start_cnt - s0);
    end
    exp_q.delete();
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    s0 = start_cnt;
    load_basic_stream();
    do_load(8'h01, 0, 0, mw);
    wait_done();
    tests++;
    if (start_cnt - s0 != 1 || err !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL abort_reload: got starts=%0d err=%b pending=%0d, required 1 0 0",
               start_cnt - s0, err, exp_q.size());
    end
    $display("[TB] abort and reload finished");
  endtask

`ifdef IM_LOADER_CSUM_EN
  task automatic test_csum();
    int s0 = start_cnt;
    int mw;
    tx_q = {8'h01, 8'h02, 8'h03, 8'h04};
    do_load(8'h00, 0, 0, mw);
    wait_done();
    tests++;
    if (start_cnt - s0 != 1 || err !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL csum_good: got starts=%0d err=%b pending=%0d, required 1 0 0", start_cnt - s0, err, exp_q.size());
    end
    s0 = start_cnt;
    do_load(8'h00, 0, 1, mw);
    wait_done();
    repeat (2) @(negedge clk);
    tests++;
    if (start_cnt - s0 != 0 || err !== 1'b1 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL csum_bad: got starts=%0d err=%b pending=%0d, required 0 1 0", start_cnt - s0, err, exp_q.size());
    end
    $display("[TB] checksum loads finished");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_overflow();
    test_full();
    test_abort();
`ifdef IM_LOADER_CSUM_EN
    test_csum();
`endif
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Writer side of the instruction-memory read interface.
- Accepts a program as a byte stream over a valid/ready handshake and packs bytes into IW-bit words.
- Writes each word into the instruction memory at consecutive addresses from 0.
- Pulses start so the core PC begins fetching once the whole image is loaded.

Parameters:
- IMW, 4, instruction memory address width; capacity 2^IMW words.
- IW, 32, instruction width; must be a multiple of 8. Local BPW = IW/8 bytes per word.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- load_req  input  1  one-cycle request to begin a load; sampled in IDLE and DONE only.
- in_byte  input  8  stream byte.
- in_valid  input  1  in_byte valid.
- in_ready  output  1  loader accepts in_byte this cycle; transfer occurs when in_valid and in_ready are both 1.
- im_we  output  1  instruction memory write enable, one-cycle pulse per word.
- im_addr  output  IMW  write address.
- im_wdata  output  IW  write data.
- start  output  1  one-cycle pulse to the core after a successful load.
- busy  output  1  high in HDR, DATA, WRITE, CSUM and START.
- done  output  1  high in DONE.
- err  output  1  sticky load error; cleared by the next accepted load_req.

Behaviour:
- Reset, asynchronous: state=IDLE. in_ready, im_we, start, busy, done and err are 0. im_addr=0, im_wdata=0. Byte index, word counter and length register are 0.
- Reset asserted mid-load aborts immediately. The partial image stays in memory and no start pulse is issued.
- All outputs are registered.
- IDLE: on load_req go to HDR and clear err.
- HDR: in_ready=1. The accepted byte is LEN; word count = LEN+1.
  - If LEN > 2^IMW-1, set err=1 and go to DONE with no writes and no start.
  - Otherwise go to DATA with byte index=0 and address=0.
- DATA: in_ready=1. Bytes are packed little-endian: byte k goes to bits [8k+7:8k].
  - When byte BPW-1 is accepted, go to WRITE.
  - Bubbles on in_valid are allowed without limit.
- WRITE: in_ready=0. im_we=1 for exactly one cycle with im_addr = word index and im_wdata = the packed word.
  - If this was the last word, go to CSUM when IM_LOADER_CSUM_EN is defined, otherwise to START.
  - Else increment the address and return to DATA.
- START: start=1 for one cycle, then go to DONE.
- DONE: done=1, in_ready=0. On load_req go to HDR, clear done and err. The memory is overwritten from address 0.
- load_req is ignored while busy.
- in_valid with in_ready=0 is not consumed; the source must hold the byte.
- Latency without checksum: last data byte accepted in cycle t, im_we in t+1, start in t+2, done from t+3.
- Address wrap cannot occur; LEN is bounded by the HDR check. LEN=2^IMW-1 writes the final address and stops.

Optional Feature:
- Macro IM_LOADER_CSUM_EN.
- Defined: a CSUM state follows the last WRITE with in_ready=1. It accepts one byte and compares it with the 8-bit modulo-256 sum of all data bytes; the header is excluded.
  - Match: go to START.
  - Mismatch: err=1, go to DONE, no start pulse.
  - Start latency: one cycle after the checksum byte is accepted.
- Undefined: no CSUM state and no checksum logic. err is set only by LEN overflow.

Test Plan:
- Reset then load_req; stream LEN=0x01, then 78 56 34 12, then EF BE AD DE -> im_we at addr 0 with 0x12345678 and at addr 1 with 0xDEADBEEF, one start pulse, done=1, err=0.
- Same stream with in_valid deasserted for 3 cycles between every byte -> identical writes and data; in_ready never drops in DATA.
- LEN=0x10 with IMW=4 -> err=1, done=1, no im_we, no start.
- LEN=0x0F with 16 words -> writes at addr 0..15, last at addr 15, start exactly once; a second load_req in DONE reloads from addr 0.
- rst_n low after 2 of 4 words -> all outputs 0 asynchronously, no start; a fresh load afterwards succeeds.
- CSUM_EN, LEN=0x00, data 01 02 03 04, checksum 0x0A -> start; same data with checksum 0x0B -> err=1, no start.
